// File: rtl/decode_pkg.sv
// decode_pkg: shared instruction definitions, field map and opcode classification for decode.
package decode_pkg;
  localparam int LEN_OPECODE = 7;
  localparam int LEN_IMMF    = 1;
  localparam int LEN_REG     = 32;
  localparam int LEN_CC      = 4;
  localparam int LEN_IMM_EX  = 32;
  localparam int LEN_REGADDR = 5;
  localparam int LEN_INSN    = 32;
  localparam int NUM_REGS    = 1 << LEN_REGADDR;
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 25;
  localparam int IMMF_BIT = 24;
  localparam int CC_MSB   = 23;
  localparam int CC_LSB   = 20;
  localparam int RD_MSB   = 19;
  localparam int RD_LSB   = 15;
  localparam int RS_MSB   = 14;
  localparam int RS_LSB   = 10;
  localparam int IMM_MSB  = 9;
  localparam int IMM_LSB  = 0;
  localparam int LEN_IMM  = IMM_MSB - IMM_LSB + 1;
  localparam logic [LEN_OPECODE-1:0] OPC_CMP = 7'b000_0100;
  localparam logic [LEN_OPECODE-1:0] OPC_LD  = 7'b001_1000;
  typedef struct packed {
    logic [LEN_OPECODE-1:0] opecode;
    logic [LEN_IMMF-1:0]    immf;
    logic [LEN_CC-1:0]      cc;
    logic [LEN_IMM_EX-1:0]  imm_ex;
    logic [LEN_REG-1:0]     data_rd;
    logic [LEN_REG-1:0]     data_rs;
    logic [LEN_REGADDR-1:0] rd_addr;
  } dec_t;
  function automatic logic writes_rd(input logic [LEN_OPECODE-1:0] opc);
    return (opc[6:4] == 3'b000 && opc != OPC_CMP) || opc[6:3] == 4'b0010 || opc == OPC_LD;
  endfunction
  function automatic logic [LEN_IMM_EX-1:0] sext_imm(input logic [LEN_IMM-1:0] imm);
    return {{(LEN_IMM_EX - LEN_IMM){imm[LEN_IMM-1]}}, imm};
  endfunction
endpackage

// File: rtl/decode_if.sv
// decode_if: fetch, writeback and execute signals of the decode stage.
interface decode_if;
  import decode_pkg::*;
  logic                   valid_i;
  logic                   stall_o;
  logic [LEN_INSN-1:0]    insn;
  logic                   wb_en;
  logic [LEN_REGADDR-1:0] wb_addr;
  logic [LEN_REG-1:0]     wb_data;
  logic                   valid_o;
  logic                   stall_i;
  logic [LEN_OPECODE-1:0] opecode;
  logic [LEN_IMMF-1:0]    immf;
  logic [LEN_CC-1:0]      cc;
  logic [LEN_IMM_EX-1:0]  imm_ex;
  logic [LEN_REG-1:0]     data_rd;
  logic [LEN_REG-1:0]     data_rs;
  logic [LEN_REGADDR-1:0] rd_addr_o;
  modport master (
    output valid_i, insn, wb_en, wb_addr, wb_data, stall_i,
    input  stall_o, valid_o, opecode, immf, cc, imm_ex, data_rd, data_rs, rd_addr_o
  );
  modport slave (
    input  valid_i, insn, wb_en, wb_addr, wb_data, stall_i,
    output stall_o, valid_o, opecode, immf, cc, imm_ex, data_rd, data_rs, rd_addr_o
  );
endinterface

// File: rtl/decode_regfile.sv
// decode_regfile: 32-entry register file, two async read ports with write-through from the write port.
module decode_regfile
  import decode_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LEN_REGADDR-1:0] ra_i,
  input  logic [LEN_REGADDR-1:0] rb_i,
  input  logic                   we_i,
  input  logic [LEN_REGADDR-1:0] wa_i,
  input  logic [LEN_REG-1:0]     wd_i,
  output logic [LEN_REG-1:0]     rda_o,
  output logic [LEN_REG-1:0]     rdb_o
);
  logic [LEN_REG-1:0] regs_q [NUM_REGS];
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    else if (we_i) regs_q[wa_i] <= wd_i;
  end
  assign rda_o = (we_i && wa_i == ra_i) ? wd_i : regs_q[ra_i];
  assign rdb_o = (we_i && wa_i == rb_i) ? wd_i : regs_q[rb_i];
endmodule

// File: rtl/decode.sv
// decode: field extraction, scoreboard hazard check and pipeline register between fetch and execute.
module decode
  import decode_pkg::*;
(
  input logic     clk,
  input logic     rst,
  decode_if.slave bus
);
  logic [LEN_REGADDR-1:0] rd, rs;
  logic [LEN_OPECODE-1:0] opc;
  logic [LEN_REG-1:0]     rf_rd, rf_rs;
  logic [NUM_REGS-1:0]    sb_q, sb_d, wb_mask, busy;
  logic                   hazard, advance, issue, valid_q;
  dec_t                   out_q, out_d;
  assign opc = bus.insn[OPC_MSB:OPC_LSB];
  assign rd  = bus.insn[RD_MSB:RD_LSB];
  assign rs  = bus.insn[RS_MSB:RS_LSB];
  decode_regfile u_rf (
    .clk   (clk),
    .rst   (rst),
    .ra_i  (rd),
    .rb_i  (rs),
    .we_i  (bus.wb_en),
    .wa_i  (bus.wb_addr),
    .wd_i  (bus.wb_data),
    .rda_o (rf_rd),
    .rdb_o (rf_rs)
  );
  // A register being written back this cycle is no longer busy, so its reader may issue now.
  assign wb_mask = bus.wb_en ? NUM_REGS'(1) << bus.wb_addr : '0;
  assign busy    = sb_q & ~wb_mask;
  assign hazard  = bus.valid_i & (busy[rd] | busy[rs]);
  assign advance = ~(valid_q & bus.stall_i);
  assign issue   = advance & bus.valid_i & ~hazard & writes_rd(opc);
  assign sb_d    = busy | (issue ? NUM_REGS'(1) << rd : '0);
  assign out_d   = '{opecode: opc, immf: bus.insn[IMMF_BIT], cc: bus.insn[CC_MSB:CC_LSB],
                     imm_ex: sext_imm(bus.insn[IMM_MSB:IMM_LSB]), data_rd: rf_rd,
                     data_rs: rf_rs, rd_addr: rd};
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q    <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      sb_q <= sb_d;
      if (advance) begin
        valid_q <= bus.valid_i & ~hazard;
        out_q   <= out_d;
      end
    end
  end
  assign bus.stall_o   = ~advance | hazard;
  assign bus.valid_o   = valid_q;
  assign bus.opecode   = out_q.opecode;
  assign bus.immf      = out_q.immf;
  assign bus.cc        = out_q.cc;
  assign bus.imm_ex    = out_q.imm_ex;
  assign bus.data_rd   = out_q.data_rd;
  assign bus.data_rs   = out_q.data_rs;
  assign bus.rd_addr_o = out_q.rd_addr;
endmodule

// File: tb/tb_decode.sv
// tb_decode: directed scenarios for decode with an expected-packet queue and a register-file model.
module tb_decode;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  decode_if b();
  decode dut (.clk(clk), .rst(rst), .bus(b));
  typedef struct packed {
    logic [6:0]  opc;
    logic        immf;
    logic [3:0]  cc;
    logic [31:0] imm;
    logic [31:0] drd;
    logic [31:0] drs;
    logic [4:0]  rd;
  } pkt_t;
  pkt_t        exp_q[$];
  logic [31:0] rf_m [32];
  int          n_cmp = 0;
  int          n_err = 0;
  function automatic logic [31:0] mk(input logic [6:0] opc, input logic immf, input logic [3:0] cc,
                                     input logic [4:0] rd, input logic [4:0] rs, input logic [9:0] imm);
    return {opc, immf, cc, rd, rs, imm};
  endfunction
  function automatic pkt_t model();
    pkt_t p;
    logic [31:0] w;
    w = b.insn;
    p.opc  = w[31:25];
    p.immf = w[24];
    p.cc   = w[23:20];
    p.imm  = {{22{w[9]}}, w[9:0]};
    p.rd   = w[19:15];
    p.drd  = (b.wb_en && b.wb_addr == w[19:15]) ? b.wb_data : rf_m[w[19:15]];
    p.drs  = (b.wb_en && b.wb_addr == w[14:10]) ? b.wb_data : rf_m[w[14:10]];
    return p;
  endfunction
  function automatic pkt_t got();
    return {b.opecode, b.immf, b.cc, b.imm_ex, b.data_rd, b.data_rs, b.rd_addr_o};
  endfunction
  task automatic drive(input logic v, input logic [31:0] w);
    b.valid_i = v;
    b.insn    = w;
  endtask
  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    b.wb_en   = en;
    b.wb_addr = a;
    b.wb_data = d;
  endtask
  task automatic push();
    exp_q.push_back(model());
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) foreach (rf_m[i]) rf_m[i] = '0;
    else if (b.wb_en) rf_m[b.wb_addr] = b.wb_data;
    #1;
  endtask
  task automatic chk_stall(input string nm, input logic exp);
    #1;
    n_cmp++;
    if (b.stall_o !== exp) begin
      n_err++;
      $display("FAIL %s: stall_o got %b want %b", nm, b.stall_o, exp);
    end
  endtask
  task automatic chk_out(input string nm, input logic exp_v, input logic pop);
    pkt_t p;
    n_cmp++;
    if (b.valid_o !== exp_v) begin
      n_err++;
      $display("FAIL %s: valid_o got %b want %b", nm, b.valid_o, exp_v);
    end
    if (exp_v) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL %s: no expected packet queued, got %h", nm, got());
      end else begin
        p = exp_q[0];
        if (got() !== p) begin
          n_err++;
          $display("FAIL %s: packet got %h want %h", nm, got(), p);
        end
        if (pop) void'(exp_q.pop_front());
      end
    end
  endtask
  task automatic wb_clear(input logic [4:0] a);
    wb(1'b1, a, 32'hA000_0000 | 32'(a));
    drive(1'b0, '0);
    tick();
    wb(1'b0, '0, '0);
  endtask
  task automatic test_reset();
    drive(1'b0, '0);
    wb(1'b1, 5'd9, 32'h1234_5678);
    b.stall_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk_out("reset_valid", 1'b0, 1'b0);
    n_cmp++;
    if (got() !== '0) begin
      n_err++;
      $display("FAIL reset_fields: got %h want 0", got());
    end
    rst = 1'b0;
    wb(1'b0, '0, '0);
    drive(1'b1, mk(7'b0011001, 1'b0, 4'h0, 5'd9, 5'd3, 10'h000));
    chk_stall("reset_first_stall", 1'b0);
    push();
    tick();
    drive(1'b0, '0);
    chk_out("reset_rf_zero", 1'b1, 1'b1);
  endtask
  task automatic test_issue();
    drive(1'b1, mk(7'b0000000, 1'b1, 4'hA, 5'd3, 5'd1, 10'h3FF));
    chk_stall("add_stall", 1'b0);
    push();
    tick();
    chk_out("add_out", 1'b1, 1'b1);
    drive(1'b1, mk(7'b0000001, 1'b0, 4'h0, 5'd6, 5'd3, 10'h000));
    chk_stall("sb3_set", 1'b1);
    tick();
    chk_out("sb3_bubble", 1'b0, 1'b0);
    wb_clear(5'd3);
  endtask
  task automatic test_wb_bypass();
    wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    drive(1'b1, mk(7'b0000001, 1'b0, 4'h3, 5'd6, 5'd5, 10'h200));
    chk_stall("bypass_stall", 1'b0);
    push();
    tick();
    wb(1'b0, '0, '0);
    drive(1'b0, '0);
    chk_out("bypass_out", 1'b1, 1'b1);
    wb_clear(5'd6);
  endtask
  task automatic test_back_to_back();
    drive(1'b1, mk(7'b0000000, 1'b0, 4'h0, 5'd3, 5'd1, 10'h001));
    chk_stall("raw_first", 1'b0);
    push();
    tick();
    drive(1'b1, mk(7'b0000001, 1'b0, 4'h1, 5'd3, 5'd3, 10'h1FF));
    chk_stall("raw_hazard", 1'b1);
    chk_out("raw_first_out", 1'b1, 1'b1);
    tick();
    chk_out("raw_bubble1", 1'b0, 1'b0);
    chk_stall("raw_hold", 1'b1);
    tick();
    chk_out("raw_bubble2", 1'b0, 1'b0);
    wb(1'b1, 5'd3, 32'hCAFE_F00D);
    chk_stall("raw_release", 1'b0);
    push();
    tick();
    wb(1'b0, '0, '0);
    drive(1'b1, mk(7'b0011001, 1'b0, 4'h0, 5'd0, 5'd3, 10'h000));
    chk_stall("raw_set_wins", 1'b1);
    chk_out("raw_second_out", 1'b1, 1'b1);
    drive(1'b0, '0);
    wb_clear(5'd3);
  endtask
  task automatic test_stall_i();
    drive(1'b1, mk(7'b0000000, 1'b0, 4'h2, 5'd7, 5'd2, 10'h0AA));
    push();
    tick();
    b.stall_i = 1'b1;
    drive(1'b1, mk(7'b0000010, 1'b1, 4'h5, 5'd8, 5'd9, 10'h155));
    for (int i = 0; i < 3; i++) begin
      chk_stall("hold_stall", 1'b1);
      chk_out("hold_out", 1'b1, 1'b0);
      tick();
    end
    b.stall_i = 1'b0;
    chk_stall("release_stall", 1'b0);
    chk_out("release_out", 1'b1, 1'b1);
    push();
    tick();
    drive(1'b0, '0);
    chk_out("after_release", 1'b1, 1'b1);
    wb_clear(5'd7);
    wb_clear(5'd8);
  endtask
  task automatic test_no_rd();
    drive(1'b1, mk(7'b0000100, 1'b0, 4'h0, 5'd2, 5'd1, 10'h000));
    chk_stall("cmp_stall", 1'b0);
    push();
    tick();
    drive(1'b1, mk(7'b0011001, 1'b0, 4'h0, 5'd2, 5'd1, 10'h004));
    chk_stall("st_stall", 1'b0);
    push();
    chk_out("cmp_out", 1'b1, 1'b1);
    tick();
    drive(1'b1, mk(7'b0000000, 1'b0, 4'h0, 5'd5, 5'd2, 10'h000));
    chk_stall("r2_reader", 1'b0);
    push();
    chk_out("st_out", 1'b1, 1'b1);
    tick();
    drive(1'b1, mk(7'b0011000, 1'b0, 4'h0, 5'd10, 5'd1, 10'h008));
    chk_stall("ld_stall", 1'b0);
    push();
    chk_out("r2_reader_out", 1'b1, 1'b1);
    tick();
    drive(1'b1, mk(7'b0000000, 1'b0, 4'h0, 5'd11, 5'd10, 10'h000));
    chk_stall("ld_sets_sb", 1'b1);
    chk_out("ld_out", 1'b1, 1'b1);
    tick();
    drive(1'b0, '0);
    chk_out("ld_bubble", 1'b0, 1'b0);
    wb_clear(5'd5);
    wb_clear(5'd10);
  endtask
  task automatic test_reset_mid();
    drive(1'b1, mk(7'b0000000, 1'b0, 4'h0, 5'd3, 5'd1, 10'h000));
    push();
    tick();
    rst = 1'b1;
    drive(1'b0, '0);
    chk_out("mid_pre", 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk_out("mid_valid", 1'b0, 1'b0);
    n_cmp++;
    if (got() !== '0) begin
      n_err++;
      $display("FAIL mid_fields: got %h want 0", got());
    end
    drive(1'b1, mk(7'b0011001, 1'b0, 4'h0, 5'd3, 5'd3, 10'h000));
    chk_stall("mid_r3_reader", 1'b0);
    push();
    tick();
    drive(1'b0, '0);
    chk_out("mid_r3_out", 1'b1, 1'b1);
  endtask
  initial begin
    foreach (rf_m[i]) rf_m[i] = '0;
    test_reset();
    test_issue();
    test_wb_bypass();
    test_back_to_back();
    test_stall_i();
    test_no_rd();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
